// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Stall/flush scheduler for the five-stage pipeline, with
//            outstanding-fetch tracking so post-exception responses are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_use_i,
    input  logic branch_flush_i,
    input  logic div_start_i,
    input  logic div_done_i,
    input  logic mem_req_i,
    input  logic mem_data_ok_i,
    input  logic inst_req_i,
    input  logic inst_addr_ok_i,
    input  logic inst_data_ok_i,
    input  logic exception_i,
    output logic stall_pc_o,
    output logic stall_if_id_o,
    output logic stall_id_ex_o,
    output logic stall_ex_mem_o,
    output logic stall_mem_wb_o,
    output logic flush_if_id_o,
    output logic flush_id_ex_o,
    output logic flush_ex_mem_o,
    output logic flush_mem_wb_o,
    output logic exception_flush_o,
    output logic div_cancel_o,
    output logic inst_discard_o,
    output logic div_busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] C_MAX = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0] C_ONE = (CNT_W + 1)'(1);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_DIV_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] r_discard_cnt;

    logic             w_fetch_acc;
    logic             w_busy;
    logic             w_mem_wait;
    logic             w_div_wait;
    logic             w_draining;
    logic [CNT_W:0]   w_out_sum;
    logic [CNT_W:0]   w_out_adj;
    logic [CNT_W-1:0] w_out_nxt;

    assign w_fetch_acc = inst_req_i & inst_addr_ok_i;
    assign w_busy      = (r_state == S_DIV_BUSY);
    assign w_mem_wait  = mem_req_i & ~mem_data_ok_i;
    assign w_div_wait  = (w_busy & ~div_done_i) | div_start_i;
    assign w_draining  = (r_discard_cnt != '0);

    // Next outstanding count, saturated to [0, MAX]; it is also exactly the
    // number of in-flight fetches that become stale when an exception hits.
    always_comb begin
        w_out_sum = {1'b0, r_out_cnt} + {{CNT_W{1'b0}}, w_fetch_acc};
        w_out_adj = w_out_sum;
        if (inst_data_ok_i && (w_out_sum != '0)) begin
            w_out_adj = w_out_sum - C_ONE;
        end
        w_out_nxt = (w_out_adj > C_MAX) ? C_MAX[CNT_W-1:0] : w_out_adj[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_out_cnt     <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_out_cnt <= w_out_nxt;

            if (exception_i) begin
                r_discard_cnt <= w_out_nxt;
            end else if (inst_data_ok_i && w_draining) begin
                r_discard_cnt <= r_discard_cnt - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // A divide finishing in its issue cycle never occupies the unit.
                    if (div_start_i && !exception_i && !div_done_i) begin
                        r_state <= S_DIV_BUSY;
                    end
                end
                default: begin
                    if (div_done_i || exception_i) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_pc_o        = 1'b0;
        stall_if_id_o     = 1'b0;
        stall_id_ex_o     = 1'b0;
        stall_ex_mem_o    = 1'b0;
        stall_mem_wb_o    = 1'b0;
        flush_if_id_o     = 1'b0;
        flush_id_ex_o     = 1'b0;
        flush_ex_mem_o    = 1'b0;
        flush_mem_wb_o    = 1'b0;
        exception_flush_o = 1'b0;
        div_cancel_o      = 1'b0;

        if (exception_i) begin
            exception_flush_o = 1'b1;
            div_cancel_o      = w_busy | div_start_i;
        end else if (w_mem_wait) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            stall_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
        end else if (w_div_wait) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
        end else if (load_use_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
        end else begin
            flush_if_id_o = branch_flush_i;
            // Hold fetch until every stale response has been swallowed.
            stall_pc_o    = w_draining;
        end
    end

    assign inst_discard_o = inst_data_ok_i & w_draining;
    assign div_busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed and randomized checks of pipe_ctrl against a
//            cycle-level reference model of the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_i, branch_flush_i, div_start_i, div_done_i;
    logic mem_req_i, mem_data_ok_i;
    logic inst_req_i, inst_addr_ok_i, inst_data_ok_i, exception_i;
    logic stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o;
    logic flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o;
    logic exception_flush_o, div_cancel_o, inst_discard_o, div_busy_o;
    logic [12:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state: divider occupied, fetches in flight, stale fetches.
    int m_busy, m_out, m_disc;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_i(load_use_i), .branch_flush_i(branch_flush_i),
        .div_start_i(div_start_i), .div_done_i(div_done_i),
        .mem_req_i(mem_req_i), .mem_data_ok_i(mem_data_ok_i),
        .inst_req_i(inst_req_i), .inst_addr_ok_i(inst_addr_ok_i),
        .inst_data_ok_i(inst_data_ok_i), .exception_i(exception_i),
        .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
        .stall_id_ex_o(stall_id_ex_o), .stall_ex_mem_o(stall_ex_mem_o),
        .stall_mem_wb_o(stall_mem_wb_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .flush_ex_mem_o(flush_ex_mem_o), .flush_mem_wb_o(flush_mem_wb_o),
        .exception_flush_o(exception_flush_o), .div_cancel_o(div_cancel_o),
        .inst_discard_o(inst_discard_o), .div_busy_o(div_busy_o)
    );

    // [12:8] stalls pc..mem_wb, [7:4] flushes if_id..mem_wb, [3] exc flush,
    // [2] div cancel, [1] inst discard, [0] div busy
    assign dut_vec = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
                      flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o,
                      exception_flush_o, div_cancel_o, inst_discard_o, div_busy_o};

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > MAX_OUT) return MAX_OUT;
        return v;
    endfunction

    function automatic logic [12:0] model_out();
        logic [12:0] v;
        v = '0;
        if (exception_i) begin
            v[3] = 1'b1;
            v[2] = (m_busy != 0) || div_start_i;
        end else if (mem_req_i && !mem_data_ok_i) begin
            v[12:9] = 4'hF;
            v[4]    = 1'b1;
        end else if (((m_busy != 0) && !div_done_i) || div_start_i) begin
            v[12:10] = 3'b111;
            v[5]     = 1'b1;
        end else if (load_use_i) begin
            v[12:11] = 2'b11;
            v[6]     = 1'b1;
        end else begin
            v[7]  = branch_flush_i;
            v[12] = (m_disc != 0);
        end
        v[1] = inst_data_ok_i && (m_disc != 0);
        v[0] = (m_busy != 0);
        return v;
    endfunction

    task automatic model_next();
        int acc;
        int dok;
        int out_after;
        acc = (inst_req_i && inst_addr_ok_i) ? 1 : 0;
        dok = inst_data_ok_i ? 1 : 0;
        out_after = clamp(m_out + acc - dok);
        if (exception_i) m_disc = out_after;
        else if (dok == 1 && m_disc > 0) m_disc = m_disc - 1;
        m_out = out_after;
        if (m_busy == 0 && div_start_i && !exception_i && !div_done_i) m_busy = 1;
        else if (m_busy != 0 && (div_done_i || exception_i)) m_busy = 0;
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_out  = 0;
        m_disc = 0;
    endtask

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        load_use_i = 0; branch_flush_i = 0; div_start_i = 0; div_done_i = 0;
        mem_req_i = 0; mem_data_ok_i = 0; inst_req_i = 0; inst_addr_ok_i = 0;
        inst_data_ok_i = 0; exception_i = 0;
    endtask

    // One cycle: inputs are already driven; compare at the falling edge.
    task automatic step(input string tag, input bit use_exp, input logic [12:0] exp);
        @(negedge clk);
        check({tag, "_model"}, dut_vec, model_out());
        if (use_exp) check(tag, dut_vec, exp);
        model_next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] e;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        check("reset_outputs", dut_vec, 13'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("after_reset", 1'b1, 13'b0);

        // Divide issued at 5, completes at 38.
        for (int c = 0; c <= 40; c++) begin
            div_start_i = (c == 5);
            div_done_i  = (c == 38);
            if (c < 5 || c > 38)   e = 13'b0;
            else if (c == 5)       e = 13'b1110000100000;
            else if (c < 38)       e = 13'b1110000100001;
            else                   e = 13'b0000000000001;
            step($sformatf("div_c%0d", c), (c == 5 || c == 6 || c == 37 || c == 38 || c == 39), e);
        end
        clear_inputs();

        // Start and done together in IDLE: one stall cycle, no occupancy.
        div_start_i = 1; div_done_i = 1;
        step("div_same_cycle", 1'b1, 13'b1110000100000);
        clear_inputs();
        step("div_same_cycle_next", 1'b1, 13'b0);

        // Data bus wait: three stalled cycles, fourth completes.
        for (int c = 0; c < 4; c++) begin
            mem_req_i = 1; mem_data_ok_i = (c == 3);
            step($sformatf("mem_c%0d", c), 1'b1, (c < 3) ? 13'b1111000010000 : 13'b0);
        end
        clear_inputs();

        // Load-use beats branch flush.
        load_use_i = 1; branch_flush_i = 1;
        step("lu_and_branch", 1'b1, 13'b1100001000000);
        clear_inputs();
        branch_flush_i = 1;
        step("branch_only", 1'b1, 13'b0000010000000);
        clear_inputs();

        // Two fetches in flight, then exception; both responses are stale.
        inst_req_i = 1; inst_addr_ok_i = 1;
        step("fetch0", 1'b1, 13'b0);
        step("fetch1", 1'b1, 13'b0);
        clear_inputs();
        exception_i = 1;
        step("exc_flush", 1'b1, 13'b0000000001000);
        clear_inputs();
        step("drain_wait0", 1'b1, 13'b1000000000000);
        inst_data_ok_i = 1;
        step("discard0", 1'b1, 13'b1000000000010);
        clear_inputs();
        step("drain_wait1", 1'b1, 13'b1000000000000);
        inst_data_ok_i = 1;
        step("discard1", 1'b1, 13'b1000000000010);
        clear_inputs();
        step("drained", 1'b1, 13'b0);
        inst_data_ok_i = 1;
        step("third_not_discarded", 1'b1, 13'b0);
        clear_inputs();

        // Exception during a divide while the data bus is stalled.
        div_start_i = 1;
        step("div_start2", 1'b0, 13'b0);
        clear_inputs();
        mem_req_i = 1;
        step("busy_mem_wait", 1'b1, 13'b1111000010001);
        exception_i = 1;
        step("exc_in_busy", 1'b1, 13'b0000000001101);
        clear_inputs();
        step("idle_after_exc", 1'b1, 13'b0);

        // Asynchronous reset in the middle of a divide and a drain.
        inst_req_i = 1; inst_addr_ok_i = 1;
        step("fetch_pre_rst", 1'b0, 13'b0);
        clear_inputs();
        exception_i = 1;
        step("exc_pre_rst", 1'b0, 13'b0);
        clear_inputs();
        div_start_i = 1;
        step("div_pre_rst", 1'b0, 13'b0);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec, 13'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 1'b1, 13'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            load_use_i     = pick(15);
            branch_flush_i = pick(15);
            div_start_i    = pick(8);
            div_done_i     = pick(10);
            mem_req_i      = pick(30);
            mem_data_ok_i  = pick(50);
            inst_req_i     = pick(50);
            inst_addr_ok_i = pick(60);
            inst_data_ok_i = pick(35);
            exception_i    = pick(5);
            step($sformatf("rand_c%0d", c), 1'b0, 13'b0);
        end
        clear_inputs();
        step("final_idle", 1'b0, 13'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
